ball_packet_tx: RTL

- Transmit end of the two-board ball hand-off link.
- On a send request, latches the current ball state and packs it into the six-byte register frame the opposite board's I2C slave decodes:
  - reg0: y[9:8] in bits 7:6
  - reg1: y[7:0]
  - reg2: signed y-velocity
  - reg3: gravity phase
  - reg4: speed flag
  - reg5: win flag
- Drives a byte-level I2C master command interface, retries on NACK or timeout, and reports completion to the game controller on is_i2c_master_done.

---
 rtl/ball_packet_tx.sv | 302 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ball_packet_tx.sv
// Ball hand-off transmitter. It latches the ball state on a send or lose edge and writes it
// as a six-byte register frame (pointer 0x00) to the peer board through a byte-level I2C
// master command port. A failed attempt is closed with STOP, followed by a back-off gap,
// and is then retried from START.
module ball_packet_tx #(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h42,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned RETRY_GAP   = 2500,
  parameter int unsigned CMD_TIMEOUT = 25000
) (
  input  logic       clk_25MHZ,
  input  logic       reset,
  input  logic       ball_send_trigger,
  input  logic       is_lose,
  input  logic [9:0] ball_y,
  input  logic [7:0] ball_vy,
  input  logic [1:0] gravity_counter,
  input  logic       speed_slow,
  output logic       is_i2c_master_done,
  output logic       tx_busy,
  output logic       tx_error,
  output logic       cmd_valid,
  output logic [1:0] cmd_op,
  output logic [7:0] cmd_data,
  input  logic       cmd_ready,
  input  logic       cmd_done,
  input  logic       cmd_nack
);

  localparam logic [1:0] OpStart = 2'd0;
  localparam logic [1:0] OpWrite = 2'd1;
  localparam logic [1:0] OpStop  = 2'd2;

  // One timer serves both the command timeout and the retry gap.
  localparam int unsigned TimerMax = (CMD_TIMEOUT > RETRY_GAP) ? CMD_TIMEOUT : RETRY_GAP;
  localparam int unsigned TimerW   = $clog2(TimerMax + 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StAddr,
    StReg,
    StData,
    StStop,
    StDone,
    StGap
  } state_e;

  state_e            state_q, state_d;
  logic              wait_q, wait_d;     // command accepted, waiting for cmd_done
  logic              fail_q, fail_d;     // the STOP in flight closes a failed attempt
  logic [TimerW-1:0] timer_q, timer_d;
  logic [2:0]        retry_q, retry_d;
  logic [2:0]        idx_q, idx_d;
  logic [5:0][7:0]   frame_q, frame_d;
  logic              trig_q, trig_d;
  logic              lose_q, lose_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              valid_q, valid_d;
  logic [1:0]        op_q, op_d;
  logic [7:0]        data_q, data_d;

  logic              rise_trig, rise_lose, start_edge;
  logic              is_write, timed_out, cmd_pass, cmd_fail, cmd_end;
  logic              begin_frame, attempt_fail, launch;
  logic [1:0]        launch_op;
  logic [7:0]        launch_data;

  function automatic logic [7:0] frame_byte(input logic [5:0][7:0] f, input logic [2:0] i);
    logic [7:0] b;
    case (i)
      3'd0:    b = f[0];
      3'd1:    b = f[1];
      3'd2:    b = f[2];
      3'd3:    b = f[3];
      3'd4:    b = f[4];
      3'd5:    b = f[5];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Next-state logic: edge detect, command handshake, frame sequencing and retry control.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    fail_d      = fail_q;
    timer_d     = timer_q;
    retry_d     = retry_q;
    idx_d       = idx_q;
    frame_d     = frame_q;
    trig_d      = ball_send_trigger;
    lose_d      = is_lose;
    done_d      = done_q;
    err_d       = err_q;
    valid_d     = valid_q;
    op_d        = op_q;
    data_d      = data_q;
    begin_frame  = 1'b0;
    attempt_fail = 1'b0;
    launch       = 1'b0;
    launch_op    = OpStart;
    launch_data  = 8'h00;

    rise_trig  = ball_send_trigger & ~trig_q;
    rise_lose  = is_lose & ~lose_q;
    start_edge = rise_trig | rise_lose;

    is_write  = (op_q == OpWrite);
    timed_out = wait_q && !cmd_done && (timer_q == TimerW'(CMD_TIMEOUT - 1));
    cmd_pass  = wait_q && cmd_done && !(cmd_nack && is_write);
    cmd_fail  = (wait_q && cmd_done && cmd_nack && is_write) || timed_out;
    cmd_end   = wait_q && (cmd_done || timed_out);

    // cmd_op/cmd_data stay put while cmd_valid waits for cmd_ready.
    if (valid_q && cmd_ready) begin
      valid_d = 1'b0;
      wait_d  = 1'b1;
      timer_d = '0;
    end else if (wait_q && !cmd_end) begin
      timer_d = timer_q + 1'b1;
    end
    if (cmd_end) begin
      wait_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (start_edge) begin
          begin_frame = 1'b1;
        end
      end
      StDone: begin
        if (start_edge) begin
          begin_frame = 1'b1;
        end else if (!ball_send_trigger && !is_lose) begin
          state_d = StIdle;
          done_d  = 1'b0;
        end
      end
      StStart: begin
        if (cmd_fail) begin
          attempt_fail = 1'b1;
        end else if (cmd_pass) begin
          state_d     = StAddr;
          launch      = 1'b1;
          launch_op   = OpWrite;
          launch_data = {SLAVE_ADDR, 1'b0};
        end
      end
      StAddr: begin
        if (cmd_fail) begin
          attempt_fail = 1'b1;
        end else if (cmd_pass) begin
          state_d     = StReg;
          launch      = 1'b1;
          launch_op   = OpWrite;
          launch_data = 8'h00;
        end
      end
      StReg: begin
        if (cmd_fail) begin
          attempt_fail = 1'b1;
        end else if (cmd_pass) begin
          state_d     = StData;
          idx_d       = 3'd0;
          launch      = 1'b1;
          launch_op   = OpWrite;
          launch_data = frame_byte(frame_q, 3'd0);
        end
      end
      StData: begin
        if (cmd_fail) begin
          attempt_fail = 1'b1;
        end else if (cmd_pass) begin
          if (idx_q == 3'd5) begin
            state_d   = StStop;
            fail_d    = 1'b0;
            launch    = 1'b1;
            launch_op = OpStop;
          end else begin
            idx_d       = idx_q + 3'd1;
            launch      = 1'b1;
            launch_op   = OpWrite;
            launch_data = frame_byte(frame_q, idx_q + 3'd1);
          end
        end
      end
      StStop: begin
        // STOP's own outcome is ignored; only the attempt result matters.
        if (cmd_end) begin
          if (!fail_q) begin
            state_d = StDone;
            done_d  = 1'b1;
            err_d   = 1'b0;
          end else if (retry_q >= 3'(MAX_RETRY)) begin
            state_d = StDone;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = StGap;
            timer_d = '0;
          end
        end
      end
      StGap: begin
        if (timer_q == TimerW'(RETRY_GAP - 1)) begin
          state_d   = StStart;
          idx_d     = 3'd0;
          retry_d   = (retry_q == 3'd7) ? retry_q : retry_q + 3'd1;
          fail_d    = 1'b0;
          launch    = 1'b1;
          launch_op = OpStart;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Latch the ball state on the same cycle the edge is seen.
    if (begin_frame) begin
      frame_d[0] = {ball_y[9:8], 6'b0};
      frame_d[1] = ball_y[7:0];
      frame_d[2] = ball_vy;
      frame_d[3] = {6'b0, gravity_counter};
      frame_d[4] = {7'b0, speed_slow};
      frame_d[5] = {7'b0, rise_lose};
      retry_d    = 3'd0;
      idx_d      = 3'd0;
      err_d      = 1'b0;
      done_d     = 1'b0;
      fail_d     = 1'b0;
      state_d    = StStart;
      launch     = 1'b1;
      launch_op  = OpStart;
    end

    if (attempt_fail) begin
      state_d   = StStop;
      fail_d    = 1'b1;
      launch    = 1'b1;
      launch_op = OpStop;
    end

    if (launch) begin
      valid_d = 1'b1;
      op_d    = launch_op;
      data_d  = launch_data;
      wait_d  = 1'b0;
    end

    busy_d = (state_d != StIdle) && (state_d != StDone);
  end

  // State and registered outputs; reset aborts any frame without issuing STOP.
  always_ff @(posedge clk_25MHZ or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      wait_q  <= 1'b0;
      fail_q  <= 1'b0;
      timer_q <= '0;
      retry_q <= 3'd0;
      idx_q   <= 3'd0;
      frame_q <= '0;
      trig_q  <= 1'b0;
      lose_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      op_q    <= 2'd0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      fail_q  <= fail_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      trig_q  <= trig_d;
      lose_q  <= lose_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      op_q    <= op_d;
      data_q  <= data_d;
    end
  end

  assign is_i2c_master_done = done_q;
  assign tx_busy            = busy_q;
  assign tx_error           = err_q;
  assign cmd_valid          = valid_q;
  assign cmd_op             = op_q;
  assign cmd_data           = data_q;

endmodule
